// File: rtl/wave_trace_render.sv
// wave_trace_render: draws the sample RAM as a scope trace over a grid, in step with
// incoming video timing. Pixels and syncs leave exactly 3 rd_clk cycles after they arrive.
module wave_trace_render #(
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 8,
    parameter int          WIN_X0    = 64,
    parameter int          WIN_Y0    = 112,
    parameter int          WIN_W     = 1024,
    parameter int          GRID_SH   = 5,
    parameter logic [23:0] TRACE_RGB = 24'h00FF00,
    parameter logic [23:0] GRID_RGB  = 24'h404040,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic              freeze,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [23:0]       rgb_out,
    output logic              frame_start
);
    localparam int CW = 16;
    localparam logic [CW-1:0] X0 = CW'(WIN_X0);
    localparam logic [CW-1:0] X1 = CW'(WIN_X0 + WIN_W);
    localparam logic [CW-1:0] Y0 = CW'(WIN_Y0);
    localparam logic [CW-1:0] Y1 = CW'(WIN_Y0 + 2**DATA_W);

    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, c, c1_q, c2_q;
    logic [DATA_W-1:0] r, r1_q, r2_q, prev_q, prev_d, p, prv, lo, hi;
    logic [2:0]        vs_q, hs_q, de_q;
    logic [1:0]        inx_q, iny_q;
    logic [23:0]       rgb_q, rgb_d;
    logic              fs_q, vs_rise, de_fall, in_x, in_y, trace, grid;

    always_comb begin
        vs_rise = vs_in && !vs_q[0];
        de_fall = de_q[0] && !de_in;
        in_x    = de_in && x_q >= X0 && x_q < X1;
        in_y    = y_q >= Y0 && y_q < Y1;
        c       = x_q[ADDR_W-1:0] - X0[ADDR_W-1:0];
        r       = y_q[DATA_W-1:0] - Y0[DATA_W-1:0];
        x_d     = de_in ? x_q + CW'(1) : '0;
        y_d     = vs_rise ? '0 : de_fall ? y_q + CW'(1) : y_q;
        base_d  = (vs_rise && !freeze) ? trig_addr : base_q;
        addr_d  = in_x ? base_q + c : addr_q;
        // sample s plots at row 2^DATA_W-1-s, i.e. its bitwise inverse
        p       = ~rd_data;
        prv     = (c2_q == '0) ? p : prev_q;
        lo      = (prv < p) ? prv : p;
        hi      = (prv < p) ? p : prv;
        trace   = inx_q[1] && iny_q[1] && r2_q >= lo && r2_q <= hi;
        grid    = inx_q[1] && iny_q[1] &&
                  (c2_q[GRID_SH-1:0] == '0 || r2_q[GRID_SH-1:0] == '0 || &r2_q);
        rgb_d   = !de_q[1] ? '0 : trace ? TRACE_RGB : grid ? GRID_RGB : BG_RGB;
        prev_d  = inx_q[1] ? p : prev_q;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
            addr_q <= '0;
            c1_q   <= '0;
            c2_q   <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            prev_q <= '0;
            vs_q   <= '0;
            hs_q   <= '0;
            de_q   <= '0;
            inx_q  <= '0;
            iny_q  <= '0;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
            addr_q <= addr_d;
            c1_q   <= c;
            c2_q   <= c1_q;
            r1_q   <= r;
            r2_q   <= r1_q;
            prev_q <= prev_d;
            vs_q   <= {vs_q[1:0], vs_in};
            hs_q   <= {hs_q[1:0], hs_in};
            de_q   <= {de_q[1:0], de_in};
            inx_q  <= {inx_q[0], in_x};
            iny_q  <= {iny_q[0], in_y};
            rgb_q  <= rgb_d;
            fs_q   <= vs_rise;
        end
    end

    assign rd_addr     = addr_q;
    assign vs_out      = vs_q[2];
    assign hs_out      = hs_q[2];
    assign de_out      = de_q[2];
    assign rgb_out     = rgb_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_wave_trace_render.sv
// tb_wave_trace_render: directed bench for wave_trace_render with a shrunken plot window
// and a registered RAM model; each test task drives its scenario and checks its own results.
module tb_wave_trace_render;
    localparam int          X0  = 2;
    localparam int          Y0  = 2;
    localparam int          W   = 30;
    localparam int          NDE = X0 + W + 2;
    localparam int          NL  = Y0 + 257;
    localparam logic [23:0] TR  = 24'h00FF00;
    localparam logic [23:0] GR  = 24'h404040;
    localparam logic [23:0] BG  = 24'h101010;

    logic        rd_clk = 1'b0;
    logic        rd_rst, vs_in, hs_in, de_in, freeze;
    logic [9:0]  trig_addr, rd_addr;
    logic [7:0]  rd_data;
    logic        vs_out, hs_out, de_out, frame_start;
    logic [23:0] rgb_out;

    logic [7:0]  ram [0:1023];
    logic        iv [0:65535];
    logic        ih [0:65535];
    logic        id [0:65535];
    logic        o_vs [0:65535];
    logic        o_hs [0:65535];
    logic        o_de [0:65535];
    logic        o_fs [0:65535];
    logic [9:0]  o_addr [0:65535];
    logic [23:0] o_rgb [0:65535];
    logic [23:0] ex_rgb [0:65535];
    int          cyc = 0, n_vec = 0, n_bad = 0, tb_base = 0;

    wave_trace_render #(
        .ADDR_W(10), .DATA_W(8), .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .GRID_SH(3),
        .TRACE_RGB(TR), .GRID_RGB(GR), .BG_RGB(BG)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .trig_addr(trig_addr), .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd_data),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out),
        .frame_start(frame_start)
    );

    always #5 rd_clk = ~rd_clk;
    always @(posedge rd_clk) rd_data <= ram[rd_addr];

    function automatic logic [23:0] exp_pix(int x, int y);
        int c, r, p, q, lo, hi;
        if (x < X0 || x >= X0 + W || y < Y0 || y >= Y0 + 256) return BG;
        c  = x - X0;
        r  = y - Y0;
        p  = 255 - int'(ram[(tb_base + c) % 1024]);
        q  = (c == 0) ? p : 255 - int'(ram[(tb_base + c + 1023) % 1024]);
        lo = (p < q) ? p : q;
        hi = (p < q) ? q : p;
        if (r >= lo && r <= hi) return TR;
        if (c % 8 == 0 || r % 8 == 0 || r == 255) return GR;
        return BG;
    endfunction

    task automatic step(input logic v, input logic h, input logic d, input logic [23:0] ex);
        if (cyc >= 65530) begin
            $display("FAIL cycle_budget cyc=%0d limit=65530", cyc);
            $fatal(1);
        end
        vs_in = v; hs_in = h; de_in = d;
        iv[cyc] = v; ih[cyc] = h; id[cyc] = d; ex_rgb[cyc] = ex;
        @(posedge rd_clk);
        @(negedge rd_clk);
        o_vs[cyc] = vs_out; o_hs[cyc] = hs_out; o_de[cyc] = de_out;
        o_fs[cyc] = frame_start; o_addr[cyc] = rd_addr; o_rgb[cyc] = rgb_out;
        cyc++;
    endtask

    task automatic line(input int y, output int d0);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
        d0 = cyc;
        for (int x = 0; x < NDE; x++) step(0, 0, 1, exp_pix(x, y));
    endtask

    task automatic vsync(output int s);
        s = cyc;
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
    endtask

    task automatic frame(output int s);
        int d;
        vsync(s);
        for (int y = 0; y < NL; y++) line(y, d);
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    endtask

    task automatic test_reset;
        rd_rst = 1'b1; vs_in = 1; hs_in = 1; de_in = 1;
        repeat (2) @(negedge rd_clk);
        n_vec += 6;
        if (rd_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", rd_addr); end
        if (rgb_out !== 24'd0) begin n_bad++; $display("FAIL reset_rgb got=%h exp=0", rgb_out); end
        if (vs_out !== 1'b0) begin n_bad++; $display("FAIL reset_vs got=%b exp=0", vs_out); end
        if (hs_out !== 1'b0) begin n_bad++; $display("FAIL reset_hs got=%b exp=0", hs_out); end
        if (de_out !== 1'b0) begin n_bad++; $display("FAIL reset_de got=%b exp=0", de_out); end
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        rd_rst = 1'b0; vs_in = 0; hs_in = 0; de_in = 0;
    endtask

    task automatic test_base_latch;
        int s, d;
        trig_addr = 10'd1000; freeze = 1'b0; tb_base = 1000;
        vsync(s);
        for (int y = 0; y <= Y0; y++) line(y, d);
        n_vec += 3;
        if (o_fs[s] !== 1'b1) begin n_bad++; $display("FAIL fs_pulse got=%b exp=1", o_fs[s]); end
        if (o_fs[s+1] !== 1'b0) begin n_bad++; $display("FAIL fs_len got=%b exp=0", o_fs[s+1]); end
        if (o_fs[s+2] !== 1'b0) begin n_bad++; $display("FAIL fs_len2 got=%b exp=0", o_fs[s+2]); end
        for (int c = 0; c < W; c++) begin
            n_vec++;
            if (o_addr[d+X0+c] !== 10'((1000 + c) % 1024)) begin
                n_bad++;
                $display("FAIL addr_wrap c=%0d got=%0d exp=%0d", c, o_addr[d+X0+c], (1000 + c) % 1024);
            end
        end
        n_vec += 3;
        if (o_addr[d+X0+24] !== 10'd0) begin n_bad++; $display("FAIL addr_col24 got=%0d exp=0", o_addr[d+X0+24]); end
        if (o_addr[d] !== 10'd5) begin n_bad++; $display("FAIL addr_hold_pre got=%0d exp=5", o_addr[d]); end
        if (o_addr[d+NDE-1] !== 10'd5) begin n_bad++; $display("FAIL addr_hold_post got=%0d exp=5", o_addr[d+NDE-1]); end
    endtask

    task automatic test_freeze;
        int s, d;
        freeze = 1'b1; trig_addr = 10'd200;
        vsync(s);
        line(0, d);
        n_vec++;
        if (o_addr[d+X0] !== 10'd1000) begin n_bad++; $display("FAIL freeze_hold got=%0d exp=1000", o_addr[d+X0]); end
        freeze = 1'b0; tb_base = 200;
        vsync(s);
        line(0, d);
        n_vec += 2;
        if (o_addr[d+X0] !== 10'd200) begin n_bad++; $display("FAIL freeze_release got=%0d exp=200", o_addr[d+X0]); end
        if (o_addr[d+X0+1] !== 10'd201) begin n_bad++; $display("FAIL freeze_next got=%0d exp=201", o_addr[d+X0+1]); end
    endtask

    task automatic test_flat;
        int s, ntr;
        for (int a = 0; a < 1024; a++) ram[a] = 8'd128;
        frame(s);
        ntr = 0;
        for (int k = s; k + 2 < cyc; k++) begin
            n_vec++;
            if (o_rgb[k+2] === TR) ntr++;
            if (o_rgb[k+2] !== ex_rgb[k]) begin
                n_bad++;
                $display("FAIL flat_rgb k=%0d got=%h exp=%h", k, o_rgb[k+2], ex_rgb[k]);
            end
        end
        n_vec++;
        if (ntr !== W) begin n_bad++; $display("FAIL flat_trace_count got=%0d exp=%0d", ntr, W); end
    endtask

    task automatic test_step;
        int s, ntr;
        for (int c = 0; c < W; c++) ram[(200 + c) % 1024] = (c < 10) ? 8'd0 : 8'd255;
        frame(s);
        ntr = 0;
        for (int k = s; k + 2 < cyc; k++) begin
            n_vec++;
            if (o_rgb[k+2] === TR) ntr++;
            if (o_rgb[k+2] !== ex_rgb[k]) begin
                n_bad++;
                $display("FAIL step_rgb k=%0d got=%h exp=%h", k, o_rgb[k+2], ex_rgb[k]);
            end
        end
        n_vec++;
        if (ntr !== 285) begin n_bad++; $display("FAIL step_trace_count got=%0d exp=285", ntr); end
    endtask

    task automatic test_sync;
        int s;
        s = cyc;
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        for (int k = s; k + 2 < cyc; k++) begin
            n_vec += 4;
            if (o_vs[k+2] !== iv[k]) begin n_bad++; $display("FAIL sync_vs k=%0d got=%b exp=%b", k, o_vs[k+2], iv[k]); end
            if (o_hs[k+2] !== ih[k]) begin n_bad++; $display("FAIL sync_hs k=%0d got=%b exp=%b", k, o_hs[k+2], ih[k]); end
            if (o_de[k+2] !== id[k]) begin n_bad++; $display("FAIL sync_de k=%0d got=%b exp=%b", k, o_de[k+2], id[k]); end
            if (!o_de[k+2] && o_rgb[k+2] !== 24'd0) begin
                n_bad++;
                $display("FAIL sync_rgb_blank k=%0d got=%h exp=0", k, o_rgb[k+2]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int s, ntr;
        for (int a = 0; a < 1024; a++) ram[a] = 8'd128;
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        de_in = 1'b1;
        #2 rd_rst = 1'b1;
        #1;
        n_vec += 5;
        if (rd_addr !== 10'd0) begin n_bad++; $display("FAIL midrst_addr got=%h exp=0", rd_addr); end
        if (rgb_out !== 24'd0) begin n_bad++; $display("FAIL midrst_rgb got=%h exp=0", rgb_out); end
        if (de_out !== 1'b0) begin n_bad++; $display("FAIL midrst_de got=%b exp=0", de_out); end
        if (vs_out !== 1'b0 || hs_out !== 1'b0) begin n_bad++; $display("FAIL midrst_sync got=%b%b exp=00", vs_out, hs_out); end
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
        @(posedge rd_clk);
        @(negedge rd_clk);
        rd_rst = 1'b0; de_in = 1'b0;
        tb_base = 200;
        frame(s);
        ntr = 0;
        for (int k = s; k + 2 < cyc; k++) begin
            n_vec++;
            if (o_rgb[k+2] === TR) ntr++;
            if (o_rgb[k+2] !== ex_rgb[k]) begin
                n_bad++;
                $display("FAIL midrst_rgb_frame k=%0d got=%h exp=%h", k, o_rgb[k+2], ex_rgb[k]);
            end
        end
        n_vec++;
        if (ntr !== W) begin n_bad++; $display("FAIL midrst_trace_count got=%0d exp=%0d", ntr, W); end
    endtask

    initial begin
        rd_rst = 1'b1; vs_in = 0; hs_in = 0; de_in = 0; freeze = 0; trig_addr = '0;
        for (int a = 0; a < 1024; a++) ram[a] = 8'd128;
        @(negedge rd_clk);
        test_reset;
        test_base_latch;
        test_freeze;
        test_flat;
        test_step;
        test_sync;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
